// File: rtl/fifo_req_scheduler_pkg.sv
// Shared types and constants for the FIFO request scheduler.
// F_D/A_W mirror the shared FIFO buffer's param_define.v values.
package fifo_req_scheduler_pkg;

  localparam int A_W = 3;
  localparam int F_D = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } schedState_t;

  // Index width that stays legal (>= 1 bit) for a single requester.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, with wrap-around.
module rr_arbiter
  import fifo_req_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idxWidth(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_allow,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic [PW-1:0] o_nxt_ptr
);

  logic w_found;

  function automatic logic [PW-1:0] wrapIdx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    o_gnt     = '0;
    o_idx     = '0;
    o_nxt_ptr = i_ptr;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_allow && i_req[wrapIdx(int'(i_ptr), k)]) begin
        w_found                          = 1'b1;
        o_idx                            = wrapIdx(int'(i_ptr), k);
        o_gnt[wrapIdx(int'(i_ptr), k)]   = 1'b1;
        o_nxt_ptr                        = wrapIdx(int'(i_ptr), k + 1);
      end
    end
  end

endmodule

// File: rtl/fifo_req_scheduler.sv
// Shares one FIFO buffer between several writers and readers; a shadow
// occupancy count guarantees every issued write/read is accepted downstream.
module fifo_req_scheduler
  import fifo_req_scheduler_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int NUM_RD = 4,
  parameter int RD_LAT = 1,
  localparam int WW = idxWidth(NUM_WR),
  localparam int RW = idxWidth(NUM_RD)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_en,
  input  logic              i_flush_req,
  input  logic [NUM_WR-1:0] i_wr_req,
  input  logic [NUM_RD-1:0] i_rd_req,
  output logic [NUM_WR-1:0] o_wr_gnt,
  output logic [NUM_RD-1:0] o_rd_gnt,
  output logic [WW-1:0]     o_wr_sel,
  output logic              o_rd_valid,
  output logic [RW-1:0]     o_rd_id,
  output logic              o_fifo_en,
  output logic              o_fifo_we,
  output logic              o_fifo_re,
  output logic              o_fifo_flush,
  output logic              o_busy
);

  localparam logic [A_W:0] CNT_FULL = (A_W + 1)'(F_D);
  localparam logic [A_W:0] CNT_ONE  = (A_W + 1)'(1);

  schedState_t               r_state;
  logic                      r_fifoEn;
  logic [A_W:0]              r_cnt;
  logic [WW-1:0]             r_wrPtr;
  logic [RW-1:0]             r_rdPtr;
  logic [RD_LAT-1:0]         r_tagValid;
  logic [RD_LAT-1:0][RW-1:0] r_tagId;

  logic              w_run, w_wrAllow, w_rdAllow, w_wrFire, w_rdFire;
  logic [NUM_WR-1:0] w_wrGnt;
  logic [NUM_RD-1:0] w_rdGnt;
  logic [WW-1:0]     w_wrIdx, w_wrNxt;
  logic [RW-1:0]     w_rdIdx, w_rdNxt;

  assign w_run     = (r_state == ST_RUN);
  assign w_rdAllow = w_run && (r_cnt != '0);
  // A full buffer can still take a write when a read frees a slot this cycle.
  assign w_wrAllow = w_run && ((r_cnt < CNT_FULL) || w_rdFire);
  assign w_wrFire  = |w_wrGnt;
  assign w_rdFire  = |w_rdGnt;

  rr_arbiter #(.N(NUM_WR)) u_wrArb (
    .i_req(i_wr_req), .i_ptr(r_wrPtr), .i_allow(w_wrAllow),
    .o_gnt(w_wrGnt), .o_idx(w_wrIdx), .o_nxt_ptr(w_wrNxt)
  );

  rr_arbiter #(.N(NUM_RD)) u_rdArb (
    .i_req(i_rd_req), .i_ptr(r_rdPtr), .i_allow(w_rdAllow),
    .o_gnt(w_rdGnt), .o_idx(w_rdIdx), .o_nxt_ptr(w_rdNxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_fifoEn <= 1'b0;
    end else begin
      r_fifoEn <= i_cfg_en;
      case (r_state)
        ST_IDLE:  if (i_flush_req) r_state <= ST_FLUSH;
                  else if (i_cfg_en) r_state <= ST_RUN;
        ST_RUN:   if (i_flush_req) r_state <= ST_FLUSH;
                  else if (!i_cfg_en) r_state <= ST_IDLE;
        ST_FLUSH: r_state <= i_cfg_en ? ST_RUN : ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Flush wipes occupancy and in-flight read tags but keeps the pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_tagValid <= '0;
      r_tagId    <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_cnt      <= '0;
      r_tagValid <= '0;
      r_tagId    <= '0;
    end else begin
      if (w_wrFire && !w_rdFire) r_cnt <= r_cnt + CNT_ONE;
      else if (w_rdFire && !w_wrFire) r_cnt <= r_cnt - CNT_ONE;
      if (w_wrFire) r_wrPtr <= w_wrNxt;
      if (w_rdFire) r_rdPtr <= w_rdNxt;
      r_tagValid[0] <= w_rdFire;
      r_tagId[0]    <= w_rdIdx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagId[i]    <= r_tagId[i-1];
      end
    end
  end

  assign o_wr_gnt     = w_wrGnt;
  assign o_rd_gnt     = w_rdGnt;
  assign o_wr_sel     = w_wrIdx;
  assign o_fifo_we    = w_wrFire;
  assign o_fifo_re    = w_rdFire;
  assign o_fifo_en    = r_fifoEn;
  assign o_fifo_flush = (r_state == ST_FLUSH);
  assign o_busy       = (r_state == ST_FLUSH);
  assign o_rd_valid   = r_tagValid[RD_LAT-1] && (r_state != ST_FLUSH);
  assign o_rd_id      = r_tagId[RD_LAT-1];

endmodule

// File: doc/fifo_req_scheduler.md
# fifo_req_scheduler

Round-robin scheduler that shares one CBG FIFO buffer (the address-update controller plus its storage) between several write requesters and several read requesters. It sits directly in front of the FIFO controller and drives its `en`/`we`/`re`/`flush` inputs. It tracks occupancy in a shadow counter so that every issued write or read is accepted downstream, and it returns per-requester grants plus a tagged read-valid strobe.

## Interface
- `NUM_WR`, default 4: number of write requesters, 1..8.
- `NUM_RD`, default 4: number of read requesters, 1..8.
- `RD_LAT`, default 1: FIFO read-data latency in cycles, 1..3.
- Depth and address width come from `F_D` and `A_W` in `param_define.v`.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_en`  in  1  scheduler enable from configuration.
- `flush_req`  in  1  single-cycle pulse; discard FIFO contents.
- `wr_req`  in  NUM_WR  per-requester write request; held until granted.
- `rd_req`  in  NUM_RD  per-requester read request; held until granted.
- `wr_gnt`  out  NUM_WR  one-hot or zero; combinational grant this cycle.
- `rd_gnt`  out  NUM_RD  one-hot or zero; combinational grant this cycle.
- `wr_sel`  out  clog2(NUM_WR)  index of the granted writer; drives the write-data mux.
- `rd_valid`  out  1  read data valid at the FIFO output, RD_LAT cycles after `rd_gnt`.
- `rd_id`  out  clog2(NUM_RD)  requester index qualified by `rd_valid`.
- `fifo_en`, `fifo_we`, `fifo_re`, `fifo_flush`  out  1 each  FIFO controller controls.
- `busy`  out  1  high while in the FLUSH state.

## Operation
- FSM states:
  - IDLE (reset state): no grants are issued.
  - RUN: arbitration is active.
  - FLUSH: a single cycle in which `fifo_flush` is asserted.
- FSM transitions:
  - IDLE→RUN when `cfg_en` is high.
  - RUN→IDLE when `cfg_en` is low.
  - RUN or IDLE→FLUSH on `flush_req`.
  - FLUSH→RUN if `cfg_en` is high, otherwise FLUSH→IDLE.
  - `flush_req` takes priority over a `cfg_en` change.
- `fifo_en` is `cfg_en` registered; it is low in IDLE.
- Shadow count `cnt` ranges 0..F_D and is `A_W+1` bits wide.
  - Write grant is allowed when `cnt < F_D`, or when `cnt == F_D` and a read is granted in the same cycle.
  - Read grant is allowed when `cnt > 0`.
  - Write only: `cnt`+1. Read only: `cnt`−1. Both or neither: `cnt` unchanged.
- Round-robin per side with pointers `wr_ptr` and `rd_ptr`.
  - The grant goes to the first requester at or after the pointer, with wrap-around.
  - On a grant, the pointer moves to the granted index + 1, modulo N.
  - The pointer does not move when nothing is granted.
- `fifo_we` = |`wr_gnt`; `fifo_re` = |`rd_gnt`. Both are combinational and in the same cycle as the grant.
- Read tag pipeline: an RD_LAT-deep shift register of {valid, id}.
- FLUSH cycle:
  - `fifo_flush` is high.
  - No grants are issued.
  - `cnt` is cleared to 0.
  - The read-tag pipeline is cleared, so in-flight `rd_valid` is suppressed.
  - Pointers keep their values.
- A `flush_req` arriving while already in FLUSH is absorbed (no second flush cycle).
- Leaving RUN for IDLE keeps `cnt` (data is retained). In-flight read tags still complete.

## Timing
- Reset values:
  - State IDLE.
  - `cnt` = 0; `wr_ptr` = `rd_ptr` = 0; tag pipeline cleared.
  - `fifo_en` = 0.
  - Consequently all grants, `fifo_we`, `fifo_re`, `fifo_flush`, `rd_valid` and `busy` are 0.
- Grant latency is 0 cycles: request at cycle t gives grant at t if allowed.
- The `cnt` update from that grant is visible at t+1.
- `rd_valid`/`rd_id` appear at t+RD_LAT for a read granted at t.
- `flush_req` at t gives FLUSH at t+1 (`fifo_flush` high for exactly that cycle) and resumes arbitration at t+2.
- Requests sampled during FLUSH are not lost; requesters hold them.
- Reset asserted mid-operation returns everything to its reset values immediately, independent of the clock.

## Structure
- Shared package: state encoding (IDLE/RUN/FLUSH), clog2 helper, and `F_D`/`A_W` import from `param_define.v`.
- One sub-module, `rr_arbiter` (parameter N; inputs req, ptr, allow; outputs gnt, idx, nxt_ptr). It is instantiated once per side.

## Test plan
- Reset then `cfg_en`=1, writer 2 alone writes `F_D` times → `cnt`=F_D. The next `wr_req` gets no grant and `fifo_we`=0.
- With `cnt`=F_D, simultaneous `wr_req[0]` and `rd_req[1]` → both granted, `cnt` stays F_D, and `rd_valid` with `rd_id`=1 appears RD_LAT cycles later.
- All four writers request continuously from `wr_ptr`=0 → grant order 0,1,2,3,0; after writer 3 is granted, `wr_ptr` is 0.
- With `cnt`=0, `rd_req`=4'b1111 → no read grant until a write occurs. After one write, reader 0 is granted on the next cycle.
- With `cnt`=5, pulse `flush_req` while a read is in flight → one `fifo_flush` cycle, `busy`=1 for that cycle, `cnt`=0, the in-flight `rd_valid` is suppressed, and grants resume 2 cycles after the pulse.
- Drop `rst` mid-burst with `cnt`=3 → all outputs go to 0 immediately; after release, state is IDLE and `cnt`=0.
